fb_read_seq: RTL and testbench
==============================

Name: fb_read_seq

Overview:
System-clock framebuffer readout sequencer. It generates framebuffer read addresses and linebuffer input enables for a scaled bitmap display. It replaces the ad-hoc line/row counters in display top levels with one parametrised block. It adds runtime vertical scale, double-buffer front/back selection with frame-synchronised swap, and overrun detection.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels (≥2)
FB_HEIGHT, 180, framebuffer height in pixels (≥1)
BUFS, 2, number of framebuffers (1 or 2)
SCALEW, 6, width of scale input (max scale 2^SCALEW-1)
ADDRW, $clog2(FB_WIDTH*FB_HEIGHT*BUFS), read address width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
frame  in  1  frame-start pulse (already in clk domain)
line  in  1  screen line-start pulse
line0  in  1  line-start pulse for the first framebuffer screen line
scale  in  SCALEW  screen lines per framebuffer row; sampled on line0; 0 treated as 1
swap_req  in  1  level; request front/back swap at next frame
addr  out  ADDRW  framebuffer read address
en  out  1  linebuffer input enable; addr valid when high
front  out  1  index of buffer being displayed
swap_ack  out  1  1-cycle pulse when a swap is applied
active  out  1  high from line0 until last row finishes
overrun  out  1  1-cycle pulse when a row read is cut short

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; addr=0, en=0, front=0, swap_ack=0, active=0, overrun=0; all internal counters 0; pending swap cleared.
- Internal registers:
  - base = front*FB_WIDTH*FB_HEIGHT
  - row_base: address of the current row
  - cnt_x: 0..FB_WIDTH-1
  - cnt_line: 0..scale_q-1
  - row: 0..FB_HEIGHT-1
  - scale_q: latched scale
- States:
  - IDLE: en=0.
    - On line0: scale_q=max(scale,1), row=0, cnt_line=0, cnt_x=0, row_base=base, active=1, go READ.
  - READ: en=1, addr=row_base+cnt_x, both registered. cnt_x increments each cycle.
    - After the cycle with cnt_x=FB_WIDTH-1: en=0, go HOLD.
    - Exactly FB_WIDTH enable cycles per row.
  - HOLD: en=0.
    - On line with cnt_line<scale_q-1: cnt_line++, stay HOLD (linebuffer repeats the row).
    - On line with cnt_line=scale_q-1 and row<FB_HEIGHT-1: cnt_line=0, row++, row_base+=FB_WIDTH, cnt_x=0, go READ.
    - On line with cnt_line=scale_q-1 and row=FB_HEIGHT-1: active=0, go IDLE.
- Overrun: a line in READ pulses overrun for 1 cycle and ends the current row read. It is then handled exactly as a line in HOLD, evaluated the same cycle. row_base stays row-aligned, so the next row still starts at base+row*FB_WIDTH.
- Frame: from any state, forces IDLE, en=0, active=0.
  - If a swap is pending and BUFS=2: front toggles and swap_ack pulses on the next cycle.
  - If a swap is pending and BUFS=1: front stays 0 but swap_ack still pulses, so drawing logic needs no special case.
  - Pending is set by swap_req=1 at any clk edge. It clears when swap_ack fires. swap_req held high swaps every frame.
- Priorities within one cycle: rst_n > frame > line0 > line.
  - frame+line0 together: frame side-effects (swap) apply, then line0 starts READ using the new base.
  - line0+line together: line0 only.
- line0 outside IDLE restarts at row 0; no overrun pulse.
- Arithmetic: addr never exceeds base+FB_WIDTH*FB_HEIGHT-1. row_base add is ADDRW bits and never wraps because row is bounded. scale is sampled only on line0; mid-frame changes are ignored.
- Latency: en/addr are registered. The first READ enable appears the cycle after line0 or line. Read data is one cycle later from BRAM; that delay is the instantiator's concern.

Test Plan:
1. FB_WIDTH=8, FB_HEIGHT=3, scale=2; line0, then line every 20 cycles -> en high 8 cycles per row; addr 0..7, then 8..15 after the 2nd line, then 16..23 after the 4th; active falls on the 6th line; no overrun.
2. scale=0 vs scale=1 -> identical traces: a new row on every line pulse.
3. Line pulses 5 cycles apart in READ -> overrun pulses; next row starts at addr 8 exactly; en count of the cut row is 5.
4. BUFS=2, swap_req pulsed once mid-frame -> front 0→1 and swap_ack 1-cycle at next frame; next line0 reads from addr 24; no further swap at the following frame. Repeat with BUFS=1 -> swap_ack pulses, front stays 0.
5. frame and line0 same cycle with swap pending -> reading starts at new base (24), swap_ack one pulse.
6. rst_n low during READ at addr 13 -> next cycle all outputs 0, state IDLE; a subsequent line is ignored until line0.

Source files
------------

// File: rtl/fb_read_seq.sv
// Framebuffer readout sequencer: per-row read addresses and linebuffer enables
// with runtime vertical scale, double-buffer swap at frame start and overrun pulses.
module fb_read_seq #(
   parameter int FB_WIDTH  = 320,
   parameter int FB_HEIGHT = 180,
   parameter int BUFS      = 2,
   parameter int SCALEW    = 6,
   parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT*BUFS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame,
   input  logic              line,
   input  logic              line0,
   input  logic [SCALEW-1:0] scale,
   input  logic              swap_req,
   output logic [ADDRW-1:0]  addr,
   output logic              en,
   output logic              front,
   output logic              swap_ack,
   output logic              active,
   output logic              overrun
);

   localparam int XW = $clog2(FB_WIDTH);
   localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
   localparam logic [ADDRW-1:0] FB_SIZE  = ADDRW'(FB_WIDTH*FB_HEIGHT);
   localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(FB_WIDTH);
   localparam logic [XW-1:0]    LAST_X   = XW'(FB_WIDTH-1);
   localparam logic [YW-1:0]    LAST_Y   = YW'(FB_HEIGHT-1);

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

   state_t              state, state_n;
   logic                pending, pend_n;
   logic                front_n, ack_n, act_n, ovr_n, en_n;
   logic [ADDRW-1:0]    addr_n, row_base, rb_n, base_n;
   logic [XW-1:0]       cnt_x, cx_n;
   logic [SCALEW-1:0]   cnt_line, cl_n, scale_q, sq_n;
   logic [YW-1:0]       row, row_n;
   logic                adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= 1'b0;
         front    <= 1'b0;
         swap_ack <= 1'b0;
         active   <= 1'b0;
         overrun  <= 1'b0;
         en       <= 1'b0;
         addr     <= '0;
         row_base <= '0;
         cnt_x    <= '0;
         cnt_line <= '0;
         row      <= '0;
         scale_q  <= '0;
      end else begin
         state    <= state_n;
         pending  <= pend_n;
         front    <= front_n;
         swap_ack <= ack_n;
         active   <= act_n;
         overrun  <= ovr_n;
         en       <= en_n;
         addr     <= addr_n;
         row_base <= rb_n;
         cnt_x    <= cx_n;
         cnt_line <= cl_n;
         row      <= row_n;
         scale_q  <= sq_n;
      end
   end

   always_comb begin
      state_n = state;
      pend_n  = pending | swap_req;
      front_n = front;
      ack_n   = 1'b0;
      act_n   = active;
      ovr_n   = 1'b0;
      en_n    = 1'b0;
      addr_n  = addr;
      rb_n    = row_base;
      cx_n    = cnt_x;
      cl_n    = cnt_line;
      row_n   = row;
      sq_n    = scale_q;
      adv     = 1'b0;

      if (frame) begin
         state_n = IDLE;
         act_n   = 1'b0;
         if (pend_n) begin
            ack_n   = 1'b1;
            pend_n  = 1'b0;
            front_n = (BUFS == 2) ? ~front : 1'b0;
         end
      end

      // line0 sees the post-swap buffer when it coincides with frame
      base_n = front_n ? FB_SIZE : '0;

      if (line0) begin
         state_n = READ;
         sq_n    = (scale == '0) ? SCALEW'(1) : scale;
         row_n   = '0;
         cl_n    = '0;
         cx_n    = '0;
         rb_n    = base_n;
         addr_n  = base_n;
         en_n    = 1'b1;
         act_n   = 1'b1;
      end else if (!frame) begin
         unique case (state)
            IDLE: ;
            READ: begin
               if (line) begin
                  ovr_n = 1'b1;
                  adv   = 1'b1;
               end else if (cnt_x == LAST_X) begin
                  state_n = HOLD;
               end else begin
                  en_n   = 1'b1;
                  cx_n   = cnt_x + XW'(1);
                  addr_n = addr + ADDRW'(1);
               end
            end
            HOLD: adv = line;
            default: state_n = IDLE;
         endcase
      end

      if (adv) begin
         if (cnt_line != scale_q - SCALEW'(1)) begin
            cl_n    = cnt_line + SCALEW'(1);
            state_n = HOLD;
         end else if (row != LAST_Y) begin
            cl_n    = '0;
            row_n   = row + YW'(1);
            rb_n    = row_base + ROW_STEP;
            addr_n  = row_base + ROW_STEP;
            cx_n    = '0;
            en_n    = 1'b1;
            state_n = READ;
         end else begin
            act_n   = 1'b0;
            state_n = IDLE;
         end
      end
   end

endmodule

// File: tb/tb_fb_read_seq.sv
// Bench for fb_read_seq: double- and single-buffer instances checked
// every cycle against a row/line-count reference model.
module tb_fb_read_seq;

   localparam int W = 8;
   localparam int H = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame = 1'b0, line = 1'b0, line0 = 1'b0, swap_req = 1'b0;
   logic [5:0] scale = '0;

   logic [5:0] addr2;
   logic [4:0] addr1;
   logic       en2, front2, ack2, act2, ovr2;
   logic       en1, front1, ack1, act1, ovr1;

   int total = 0;
   int bad = 0;
   int en_cnt = 0;

   bit m_front, m_pend, m_run, m_ack, m_ovr;
   int m_left, m_lines, m_sq;

   always #5 clk = ~clk;

   fb_read_seq #(.FB_WIDTH(W), .FB_HEIGHT(H), .BUFS(2), .SCALEW(6)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .line0(line0),
      .scale(scale), .swap_req(swap_req), .addr(addr2), .en(en2),
      .front(front2), .swap_ack(ack2), .active(act2), .overrun(ovr2)
   );

   fb_read_seq #(.FB_WIDTH(W), .FB_HEIGHT(H), .BUFS(1), .SCALEW(6)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .line0(line0),
      .scale(scale), .swap_req(swap_req), .addr(addr1), .en(en1),
      .front(front1), .swap_ack(ack1), .active(act1), .overrun(ovr1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a row is W pixels long; line pulses are counted per frame
   // and every scale-th one starts the next row.
   task automatic model_edge();
      bit pe;
      m_ack = 0;
      m_ovr = 0;
      if (!rst_n) begin
         m_front = 0; m_pend = 0; m_run = 0;
         m_left = 0; m_lines = 0; m_sq = 1;
      end else begin
         pe = m_pend | swap_req;
         m_pend = pe;
         if (frame) begin
            m_run = 0;
            m_left = 0;
            if (pe) begin
               m_ack = 1;
               m_pend = 0;
               m_front = ~m_front;
            end
         end
         if (line0) begin
            m_sq = (scale == 0) ? 1 : int'(scale);
            m_lines = 0;
            m_run = 1;
            m_left = W;
         end else if (!frame && m_run && line) begin
            if (m_left > 0) m_ovr = 1;
            m_left = 0;
            m_lines++;
            if (m_lines == H*m_sq) m_run = 0;
            else if (m_lines % m_sq == 0) m_left = W;
         end else if (!frame && m_left > 0) begin
            m_left--;
         end
      end
   endtask

   task automatic check_outs();
      int off;
      off = (m_lines / m_sq) * W + (W - m_left);
      chk("en2", en2, m_left > 0);
      chk("en1", en1, m_left > 0);
      if (m_left > 0) begin
         chk("addr2", addr2, m_front * W * H + off);
         chk("addr1", addr1, off);
      end
      chk("front2", front2, m_front);
      chk("front1", front1, 0);
      chk("ack2", ack2, m_ack);
      chk("ack1", ack1, m_ack);
      chk("act2", act2, m_run);
      chk("act1", act1, m_run);
      chk("ovr2", ovr2, m_ovr);
      chk("ovr1", ovr1, m_ovr);
      if (en2) en_cnt++;
   endtask

   task automatic step(input logic f, input logic l0, input logic l,
                       input logic sr, input logic [5:0] sc);
      frame = f; line0 = l0; line = l; swap_req = sr; scale = sc;
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic idle(input int n, input logic [5:0] sc);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, sc);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_addr2", addr2, 0);
      chk("rst_addr1", addr1, 0);

      // scale 2, line every 20 cycles
      en_cnt = 0;
      step(0, 1, 0, 0, 2);
      idle(19, 2);
      chk("row_len", en_cnt, W);
      for (int k = 0; k < 6; k++) begin
         step(0, 0, 1, 0, 2);
         idle(19, 2);
      end
      chk("t1_active_end", act2, 0);

      // scale 0 behaves as scale 1
      for (int s = 0; s < 2; s++) begin
         step(0, 1, 0, 0, 6'(s));
         for (int k = 0; k < 3; k++) begin
            idle(11, 6'(s));
            step(0, 0, 1, 0, 6'(s));
            if (k < 2) chk("t2_newrow", en2, 1);
         end
         idle(3, 0);
      end

      // line pulses 5 cycles apart cut the row short
      en_cnt = 0;
      step(0, 1, 0, 0, 1);
      idle(4, 1);
      chk("cut_len", en_cnt, 5);
      step(0, 0, 1, 0, 1);
      chk("cut_ovr", ovr2, 1);
      chk("cut_next", addr2, 8);
      idle(4, 1);
      step(0, 0, 1, 0, 1);
      idle(12, 1);

      // frame and line0 together with a swap pending
      do_reset();
      step(0, 0, 0, 1, 1);
      step(1, 1, 0, 0, 1);
      chk("fl0_addr", addr2, 24);
      chk("fl0_ack", ack2, 1);
      step(0, 0, 0, 0, 1);
      chk("fl0_ack_once", ack2, 0);
      idle(10, 1);

      // single swap request mid-frame: front 1 -> 0, one swap only
      step(0, 0, 0, 1, 1);
      idle(5, 1);
      step(1, 0, 0, 0, 1);
      chk("sw_front", front2, 0);
      chk("sw_ack1", ack1, 1);
      step(0, 1, 0, 0, 1);
      chk("sw_addr", addr2, 0);
      idle(10, 1);
      step(1, 0, 0, 0, 1);
      chk("sw_noack", ack2, 0);
      idle(3, 1);

      // reset in the middle of a row read
      step(0, 1, 0, 0, 1);
      idle(10, 1);
      step(0, 0, 1, 0, 1);
      idle(5, 1);
      chk("pre_rst_addr", addr1, 13);
      rst_n = 1'b0;
      step(0, 0, 0, 0, 1);
      chk("rst_mid_addr", addr2, 0);
      chk("rst_mid_en", en2, 0);
      rst_n = 1'b1;
      step(0, 0, 1, 0, 1);
      chk("rst_line_ign", en2, 0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         rst_n = ($urandom_range(0, 599) != 0);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 119) == 0,
              $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
              6'($urandom_range(0, 3)));
      end
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
